// File: rtl/tage_update_if.sv
// Update-request and table-write-port bundle for the TAGE update block.
// The master drives resolved branches and observes the write port.
interface tage_update_if #(
    parameter int NBANK = 12
);
    logic                  upd_valid;
    logic                  upd_ready;
    logic                  upd_taken;
    logic                  upd_pred_dir;
    logic                  upd_alt_dir;
    logic                  upd_prov_hit;
    logic [3:0]            upd_provider;
    logic [NBANK*12-1:0]   upd_index;
    logic [NBANK*15-1:0]   upd_tag;
    logic [NBANK*20-1:0]   upd_entry;
    logic [19:0]           updateData;
    logic [11:0]           updateIndex;
    logic [NBANK-1:0]      upWren;
    logic                  use_alt;

    modport master (
        output upd_valid, upd_taken, upd_pred_dir, upd_alt_dir, upd_prov_hit,
               upd_provider, upd_index, upd_tag, upd_entry,
        input  upd_ready, updateData, updateIndex, upWren, use_alt
    );

    modport slave (
        input  upd_valid, upd_taken, upd_pred_dir, upd_alt_dir, upd_prov_hit,
               upd_provider, upd_index, upd_tag, upd_entry,
        output upd_ready, updateData, updateIndex, upWren, use_alt
    );
endinterface

// File: rtl/tage_update.sv
// Purpose: TAGE update side; provider refresh, allocation on mispredict, usefulness decay.
// Latency: provider write 1 cycle after accept, allocation 1-2 cycles, decay 1 cycle per bank.
// Backpressure: upd_ready is high only in IDLE; one request in flight, one table write per cycle.
module tage_update #(
    parameter int         NBANK     = 12,
    parameter logic [3:0] UANA_INIT = 4'd8
) (
    input  logic          clk,
    input  logic          reset,
    tage_update_if.slave  up
);

    typedef enum logic [1:0] {IDLE, PROV, ALLOC, DECAY} state_t;

    typedef struct packed {
        logic                taken;
        logic                pred_dir;
        logic                alt_dir;
        logic                mispred;
        logic [3:0]          provider;
        logic [3:0]          start;
        logic [1:0]          seed;
        logic [NBANK*12-1:0] index;
        logic [NBANK*15-1:0] tag;
        logic [NBANK*20-1:0] entry;
    } req_t;

    function automatic logic [4:0] tag_bits(input logic [3:0] b);
        case (b)
            4'd0, 4'd1: tag_bits = 5'd7;
            4'd2, 4'd3: tag_bits = 5'd8;
            4'd4:       tag_bits = 5'd9;
            4'd5:       tag_bits = 5'd10;
            4'd6:       tag_bits = 5'd11;
            4'd7, 4'd8: tag_bits = 5'd12;
            4'd9:       tag_bits = 5'd13;
            4'd10:      tag_bits = 5'd14;
            default:    tag_bits = 5'd15;
        endcase
    endfunction

    function automatic logic [3:0] idx_bits(input logic [3:0] b);
        case (b)
            4'd2, 4'd3, 4'd4, 4'd5: idx_bits = 4'd11;
            4'd10, 4'd11:           idx_bits = 4'd9;
            default:                idx_bits = 4'd10;
        endcase
    endfunction

    state_t           state, state_n;
    req_t             req, req_n;
    logic [1:0]       seed;
    logic [3:0]       uana;
    logic [3:0]       ptr, ptr_n;
    logic             accept;

    logic [NBANK-1:0] cand;
    logic [1:0]       ncand;
    logic [3:0]       lo, lo2, pick;

    logic [4:0]       ptb;
    logic [19:0]      pent, pdata;
    logic [1:0]       pctr, pctr_n;
    logic [2:0]       pu, pu_n;

    logic             wr_any;
    logic [3:0]       wr_bank;
    logic [4:0]       atb;
    logic [19:0]      dent, data_n;
    logic [11:0]      idx_n;
    logic [NBANK-1:0] wren_n;

    assign up.upd_ready = (state == IDLE);
    assign up.use_alt   = uana[3];
    assign accept       = up.upd_valid && up.upd_ready;

    // Request view for the coming cycle: fresh inputs on accept, held copy otherwise.
    always_comb begin
        req_n = req;
        if (accept) begin
            req_n.taken    = up.upd_taken;
            req_n.pred_dir = up.upd_pred_dir;
            req_n.alt_dir  = up.upd_alt_dir;
            req_n.mispred  = up.upd_pred_dir != up.upd_taken;
            req_n.provider = up.upd_provider;
            req_n.start    = up.upd_prov_hit ? up.upd_provider + 4'd1 : 4'd0;
            req_n.seed     = seed;
            req_n.index    = up.upd_index;
            req_n.tag      = up.upd_tag;
            req_n.entry    = up.upd_entry;
        end
    end

    // Free banks at or above start; remember the two lowest.
    always_comb begin
        cand  = '0;
        ncand = 2'd0;
        lo    = 4'd0;
        lo2   = 4'd0;
        for (int j = 0; j < NBANK; j++) begin
            cand[j] = (4'(j) >= req_n.start) && (req_n.entry[20*j +: 3] == 3'd0);
            if (cand[j]) begin
                if (ncand == 2'd0)      lo  = 4'(j);
                else if (ncand == 2'd1) lo2 = 4'(j);
                if (ncand != 2'd2) ncand = ncand + 2'd1;
            end
        end
        pick = (req_n.seed == 2'd3 && ncand == 2'd2) ? lo2 : lo;
    end

    always_comb begin
        ptb    = tag_bits(req_n.provider);
        pent   = req_n.entry[20*req_n.provider +: 20];
        pctr   = 2'(pent >> (ptb + 5'd3));
        pu     = pent[2:0];
        if (req_n.taken) pctr_n = (pctr == 2'd3) ? 2'd3 : pctr + 2'd1;
        else             pctr_n = (pctr == 2'd0) ? 2'd0 : pctr - 2'd1;
        pu_n = pu;
        if (req_n.pred_dir != req_n.alt_dir) begin
            if (req_n.pred_dir == req_n.taken) pu_n = (pu == 3'd7) ? 3'd7 : pu + 3'd1;
            else                               pu_n = (pu == 3'd0) ? 3'd0 : pu - 3'd1;
        end
        pdata = (pent & ~((20'h3 << (ptb + 5'd3)) | 20'h7))
              | (20'(pctr_n) << (ptb + 5'd3)) | 20'(pu_n);
    end

    // Next state plus the write that the next state will present.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        wr_any  = 1'b0;
        wr_bank = 4'd0;
        data_n  = 20'd0;
        atb     = tag_bits(pick);
        dent    = 20'd0;
        case (state)
            IDLE: if (accept) begin
                if (up.upd_prov_hit)                       state_n = PROV;
                else if (up.upd_pred_dir != up.upd_taken)  state_n = ALLOC;
            end
            PROV:  state_n = (req.mispred && req.start <= 4'(NBANK-1)) ? ALLOC : IDLE;
            ALLOC: begin
                if (ncand == 2'd0) begin
                    state_n = DECAY;
                    ptr_n   = req.start;
                end else begin
                    state_n = IDLE;
                end
            end
            DECAY: begin
                ptr_n = ptr + 4'd1;
                if (ptr == 4'(NBANK-1)) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        case (state_n)
            PROV: begin
                wr_any  = 1'b1;
                wr_bank = req_n.provider;
                data_n  = pdata;
            end
            ALLOC: if (ncand != 2'd0) begin
                wr_any  = 1'b1;
                wr_bank = pick;
                data_n  = ((req_n.taken ? 20'h2 : 20'h1) << (atb + 5'd3))
                        | ((20'(req_n.tag[15*pick +: 15]) & ((20'h1 << atb) - 20'h1)) << 3);
            end
            DECAY: begin
                wr_any  = 1'b1;
                wr_bank = ptr_n;
                dent    = req_n.entry[20*ptr_n +: 20];
                data_n  = {dent[19:3], dent[2:0] - 3'd1};
            end
            default: ;
        endcase

        wren_n = wr_any ? ({{(NBANK-1){1'b0}}, 1'b1} << wr_bank) : '0;
        idx_n  = wr_any ? (req_n.index[12*wr_bank +: 12] & ((12'h1 << idx_bits(wr_bank)) - 12'h1))
                        : 12'd0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            ptr            <= 4'd0;
            seed           <= 2'd0;
            uana           <= UANA_INIT;
            req            <= '0;
            up.upWren      <= '0;
            up.updateData  <= 20'd0;
            up.updateIndex <= 12'd0;
        end else begin
            state          <= state_n;
            ptr            <= ptr_n;
            req            <= req_n;
            up.upWren      <= wren_n;
            up.updateData  <= data_n;
            up.updateIndex <= idx_n;
            if (accept) seed <= seed + 2'd1;
            // Weak, newly allocated provider disagreeing with alt trains the alt-on-NA choice.
            if (state_n == PROV && req_n.pred_dir != req_n.alt_dir && pu == 3'd0 &&
                (pctr == 2'd1 || pctr == 2'd2)) begin
                if (req_n.alt_dir == req_n.taken) uana <= (uana == 4'd15) ? 4'd15 : uana + 4'd1;
                else                              uana <= (uana == 4'd0)  ? 4'd0  : uana - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_tage_update.sv
// Bench for tage_update: directed cases plus random branches against a list-based reference model.
module tb_tage_update;
    localparam int NB = 12;
    localparam int TBW [NB] = '{7, 7, 8, 8, 9, 10, 11, 12, 12, 13, 14, 15};
    localparam int IW  [NB] = '{10, 10, 11, 11, 11, 11, 10, 10, 10, 10, 9, 9};

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    tage_update_if #(.NBANK(NB)) uif ();

    tage_update #(.NBANK(NB), .UANA_INIT(4'd8)) dut (
        .clk   (clk),
        .reset (reset),
        .up    (uif)
    );

    logic        t_taken, t_pred, t_alt, t_hit;
    logic [3:0]  t_prov;
    logic [19:0] t_entry [NB];
    logic [14:0] t_tag   [NB];
    logic [11:0] t_index [NB];

    int          m_seed, m_uana;
    logic [11:0] exp_wren [$];
    logic [11:0] exp_idx  [$];
    logic [19:0] exp_data [$];
    logic [11:0] obs_wren [16];
    logic [19:0] obs_data [16];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic logic [19:0] mk(input int b, input int c, input int tg, input int u);
        return 20'((c << (TBW[b] + 3)) | ((tg & ((1 << TBW[b]) - 1)) << 3) | (u & 7));
    endfunction

    function automatic logic [11:0] idxm(input int b);
        return 12'(int'(t_index[b]) & ((1 << IW[b]) - 1));
    endfunction

    task automatic push_w(input logic [11:0] w, input logic [11:0] i, input logic [19:0] d);
        exp_wren.push_back(w);
        exp_idx.push_back(i);
        exp_data.push_back(d);
    endtask

    // Reference: list of per-cycle writes derived from the update rules.
    task automatic model_txn();
        int free_q [$];
        int s, start, ci, ui, tg, nc, nu, j;
        exp_wren.delete(); exp_idx.delete(); exp_data.delete();
        start  = t_hit ? int'(t_prov) + 1 : 0;
        s      = m_seed;
        m_seed = (m_seed + 1) % 4;
        if (t_hit) begin
            j  = int'(t_prov);
            ui = int'(t_entry[j]) & 7;
            tg = (int'(t_entry[j]) >> 3) & ((1 << TBW[j]) - 1);
            ci = (int'(t_entry[j]) >> (TBW[j] + 3)) & 3;
            nc = t_taken ? ((ci < 3) ? ci + 1 : 3) : ((ci > 0) ? ci - 1 : 0);
            nu = ui;
            if (t_pred != t_alt)
                nu = (t_pred == t_taken) ? ((ui < 7) ? ui + 1 : 7) : ((ui > 0) ? ui - 1 : 0);
            push_w(12'(1 << j), idxm(j), mk(j, nc, tg, nu));
            if (ui == 0 && (ci == 1 || ci == 2) && t_pred != t_alt)
                m_uana = (t_alt == t_taken) ? ((m_uana < 15) ? m_uana + 1 : 15)
                                            : ((m_uana > 0) ? m_uana - 1 : 0);
        end
        if (t_pred != t_taken && start <= NB - 1) begin
            for (int b = start; b < NB; b++)
                if ((int'(t_entry[b]) & 7) == 0) free_q.push_back(b);
            if (free_q.size() > 0) begin
                j = (s == 3 && free_q.size() >= 2) ? free_q[1] : free_q[0];
                push_w(12'(1 << j), idxm(j), mk(j, t_taken ? 2 : 1, int'(t_tag[j]), 0));
            end else begin
                push_w(12'd0, 12'd0, 20'd0);
                for (int b = start; b < NB; b++) begin
                    ui = int'(t_entry[b]) & 7;
                    tg = (int'(t_entry[b]) >> 3) & ((1 << TBW[b]) - 1);
                    ci = (int'(t_entry[b]) >> (TBW[b] + 3)) & 3;
                    push_w(12'(1 << b), idxm(b), mk(b, ci, tg, ui - 1));
                end
            end
        end
    endtask

    task automatic drive_inputs();
        uif.upd_taken    = t_taken;
        uif.upd_pred_dir = t_pred;
        uif.upd_alt_dir  = t_alt;
        uif.upd_prov_hit = t_hit;
        uif.upd_provider = t_prov;
        for (int b = 0; b < NB; b++) begin
            uif.upd_index[12*b +: 12] = t_index[b];
            uif.upd_tag[15*b +: 15]   = t_tag[b];
            uif.upd_entry[20*b +: 20] = t_entry[b];
        end
    endtask

    // Called #1 after a clock edge with the DUT idle.
    task automatic run_txn();
        int n;
        model_txn();
        n = exp_wren.size();
        chk("ready_before", 32'(uif.upd_ready), 32'd1);
        drive_inputs();
        uif.upd_valid = 1'b1;
        @(posedge clk); #1;
        uif.upd_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            obs_wren[k+1] = uif.upWren;
            obs_data[k+1] = uif.updateData;
            chk("wren", 32'(uif.upWren), 32'(exp_wren[k]));
            if (exp_wren[k] != 12'd0) begin
                chk("windex", 32'(uif.updateIndex), 32'(exp_idx[k]));
                chk("wdata", 32'(uif.updateData), 32'(exp_data[k]));
            end
            chk("busy", 32'(uif.upd_ready), 32'd0);
            @(posedge clk); #1;
        end
        obs_wren[n+1] = uif.upWren;
        chk("idle_wren", 32'(uif.upWren), 32'd0);
        chk("idle_ready", 32'(uif.upd_ready), 32'd1);
        chk("use_alt", 32'(uif.use_alt), 32'(m_uana >= 8));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        uif.upd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b1;
        m_seed = 0;
        m_uana = 8;
    endtask

    task automatic set_all(input int u);
        for (int b = 0; b < NB; b++) begin
            t_entry[b] = mk(b, 1, b * 37 + 5, u);
            t_tag[b]   = 15'(16'h5A5A + b);
            t_index[b] = 12'(12'hF00 + b * 17);
        end
    endtask

    task automatic set_br(input logic hit, input int prov, input logic pred, input logic alt, input logic tk);
        t_hit = hit; t_prov = 4'(prov); t_pred = pred; t_alt = alt; t_taken = tk;
    endtask

    initial begin
        uif.upd_valid = 1'b0;
        set_br(1'b0, 0, 1'b0, 1'b0, 1'b0);
        set_all(1);
        drive_inputs();
        do_reset();

        chk("rst_wren", 32'(uif.upWren), 32'd0);
        chk("rst_data", 32'(uif.updateData), 32'd0);
        chk("rst_index", 32'(uif.updateIndex), 32'd0);
        chk("rst_ready", 32'(uif.upd_ready), 32'd1);
        chk("rst_use_alt", 32'(uif.use_alt), 32'd1);

        // Provider hit, correct, pred == alt.
        set_all(1);
        t_entry[3] = mk(3, 2, 8'hA5, 5);
        set_br(1'b1, 3, 1'b1, 1'b1, 1'b1);
        run_txn();
        chk("prov_ok_wren", 32'(obs_wren[1]), 32'h008);
        chk("prov_ok_data", 32'(obs_data[1]), 32'h1D2D);
        chk("prov_ok_idle", 32'(obs_wren[2]), 32'd0);

        // Provider mispredict with bank 3 free.
        set_all(1);
        t_entry[2] = mk(2, 2, 8'h3C, 1);
        t_entry[3] = mk(3, 3, 8'h11, 0);
        t_tag[3]   = 15'h7ABC;
        set_br(1'b1, 2, 1'b1, 1'b0, 1'b0);
        run_txn();
        chk("mis_prov_data", 32'(obs_data[1]), 32'h009E0);
        chk("mis_alloc_wren", 32'(obs_wren[2]), 32'h008);
        chk("mis_alloc_data", 32'(obs_data[2]), 32'h00DE0);

        // Seed selection: fourth accept after reset sees seed 3.
        do_reset();
        set_all(1);
        set_br(1'b0, 0, 1'b1, 1'b1, 1'b1);
        repeat (3) run_txn();
        t_entry[0] = mk(0, 1, 3, 0);
        t_entry[5] = mk(5, 2, 9, 0);
        set_br(1'b0, 0, 1'b1, 1'b0, 1'b0);
        run_txn();
        chk("seed_pick", 32'(obs_wren[1]), 32'h020);

        // Decay path above provider 8.
        set_all(2);
        set_br(1'b1, 8, 1'b1, 1'b1, 1'b0);
        run_txn();
        chk("decay_gap", 32'(obs_wren[2]), 32'd0);
        chk("decay_b9", 32'(obs_wren[3]), 32'h200);
        chk("decay_b11", 32'(obs_wren[5]), 32'h800);
        chk("decay_u", 32'(obs_data[5][2:0]), 32'd1);
        chk("decay_done", 32'(obs_wren[6]), 32'd0);

        // USE_ALT_ON_NA saturates high, then walks down to zero.
        do_reset();
        set_all(0);
        t_entry[0] = mk(0, 1, 7, 0);
        set_br(1'b1, 0, 1'b0, 1'b1, 1'b1);
        repeat (8) run_txn();
        chk("uana_high", 32'(uif.use_alt), 32'd1);
        set_br(1'b1, 0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            run_txn();
            chk("uana_fall", 32'(uif.use_alt), 32'(i < 7));
        end
        chk("uana_low", 32'(uif.use_alt), 32'd0);

        // Reset during the second decay cycle.
        set_all(2);
        set_br(1'b1, 8, 1'b1, 1'b1, 1'b0);
        drive_inputs();
        uif.upd_valid = 1'b1;
        @(posedge clk); #1;
        uif.upd_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("rmd_dec1", 32'(uif.upWren), 32'h200);
        @(posedge clk); #1;
        chk("rmd_dec2", 32'(uif.upWren), 32'h400);
        reset = 1'b0;
        @(posedge clk); #1;
        reset  = 1'b1;
        m_seed = 0;
        m_uana = 8;
        chk("rmd_wren", 32'(uif.upWren), 32'd0);
        chk("rmd_ready", 32'(uif.upd_ready), 32'd1);
        chk("rmd_data", 32'(uif.updateData), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("rmd_quiet", 32'(uif.upWren), 32'd0);
        end
        chk("rmd_use_alt", 32'(uif.use_alt), 32'd1);

        // Random branches.
        for (int n = 0; n < 300; n++) begin
            for (int b = 0; b < NB; b++) begin
                t_entry[b] = mk(b, int'($urandom_range(0, 3)), int'($urandom_range(0, 32767)),
                                ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 7)));
                t_tag[b]   = 15'($urandom);
                t_index[b] = 12'($urandom);
            end
            set_br(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 11)),
                   1'($urandom), 1'($urandom), 1'($urandom));
            run_txn();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
